spi_peripheral: RTL

SPI target front end that turns SPI frames from an external host into single-beat transactions on the register-bank application interface (wr_rdn/addr/wdata/we/ack/rdata/err). It sits directly upstream of reg_bank. It oversamples the SPI pins with the system clock and supports SPI mode 0 (CPOL=0, CPHA=0), MSB first. Read data returned by the bank is shifted back out on MISO within the same frame.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_peripheral_synchronizer.sv | 27 ++
 rtl/spi_peripheral.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and frame constants for the
// SPI target front end (spi_peripheral).
package spi_pkg;

  localparam int SPI_ADDR_W = 8;
  localparam int SPI_REG_W  = 8;
  localparam int HDR_BITS   = 1 + SPI_ADDR_W;
  localparam int FRAME_BITS = HDR_BITS + SPI_REG_W;

  localparam logic WR_BIT = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    RD_REQ,
    WDATA,
    DATA,
    WR_REQ,
    DONE
  } state_t;

endpackage

// File: rtl/spi_peripheral_synchronizer.sv
// synchronizer: 2-FF synchroniser for one asynchronous input.
// Ports: clk, rst_n (async active-low), d_i (async in), q_o (sync out).
module synchronizer #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-0 target turning frames into single-beat
// register-bank transactions.
// Ports: clk, rstb, ena; spi_cs_n/sclk/mosi in, spi_miso/_oe out;
// bank side wr_rdn/addr/wdata/we out, ack/rdata/err in;
// bus_err and frame_abort one-cycle status pulses.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int ADDR_W = SPI_ADDR_W,
  parameter int REG_W  = SPI_REG_W
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              wr_rdn,
  output logic [ADDR_W-1:0] addr,
  output logic [REG_W-1:0]  wdata,
  output logic              we,
  input  logic              ack,
  input  logic [REG_W-1:0]  rdata,
  input  logic              err,
  output logic              bus_err,
  output logic              frame_abort
);

  localparam int HDR_N   = 1 + ADDR_W;
  localparam int CNT_MAX = (HDR_N > REG_W) ? HDR_N : REG_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_N - 1);
  localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(REG_W - 1);
  localparam logic [CNT_W-1:0] DAT_ALL  = CNT_W'(REG_W);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic cs_s, sclk_s, mosi_s;
  logic sclk_d_q;
  logic rise, fall;

  synchronizer #(.RST_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .rst_n (rstb),
    .d_i   (spi_cs_n),
    .q_o   (cs_s)
  );

  synchronizer #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rstb),
    .d_i   (spi_sclk),
    .q_o   (sclk_s)
  );

  synchronizer #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst_n (rstb),
    .d_i   (spi_mosi),
    .q_o   (mosi_s)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) sclk_d_q <= 1'b0;
    else       sclk_d_q <= sclk_s;
  end

  assign rise = sclk_s & ~sclk_d_q;
  assign fall = ~sclk_s & sclk_d_q;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HDR_N-1:0]   hdr_q, hdr_d, hdr_nx;
  logic [REG_W-1:0]   rx_q, rx_d, rx_nx;
  logic [REG_W-1:0]   tx_q, tx_d;
  logic               miso_q, miso_d;
  logic               we_q, we_d;
  logic               wr_rdn_q, wr_rdn_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [REG_W-1:0]   wdata_q, wdata_d;
  logic               berr_q, berr_d;
  logic               abort_q, abort_d;
  // late_q: a data rise arrived before the read ack, MISO stays 0
  logic               late_q, late_d;
  // rose_q: a rise was seen in DATA, so falls now shift MISO
  logic               rose_q, rose_d;
  // quit_q/cshi_q: frame ended while a handshake was pending
  logic               quit_q, quit_d;
  logic               cshi_q, cshi_d;

  assign hdr_nx = {hdr_q[HDR_N-2:0], mosi_s};
  assign rx_nx  = {rx_q[REG_W-2:0], mosi_s};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hdr_d    = hdr_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    miso_d   = miso_q;
    we_d     = we_q;
    wr_rdn_d = wr_rdn_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    berr_d   = 1'b0;
    abort_d  = 1'b0;
    late_d   = late_q;
    rose_d   = rose_q;
    quit_d   = quit_q;
    cshi_d   = cshi_q;

    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        we_d   = 1'b0;
        if (ena && !cs_s) begin
          cnt_d   = '0;
          hdr_d   = '0;
          rx_d    = '0;
          tx_d    = '0;
          late_d  = 1'b0;
          rose_d  = 1'b0;
          quit_d  = 1'b0;
          cshi_d  = 1'b0;
          state_d = HDR;
        end
      end

      HDR: begin
        if (cs_s) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (!ena) begin
          state_d = IDLE;
        end else if (rise) begin
          hdr_d = hdr_nx;
          if (cnt_q == HDR_LAST) begin
            cnt_d = '0;
            if (hdr_nx[HDR_N-1] == WR_BIT) begin
              state_d = WDATA;
            end else begin
              we_d     = 1'b1;
              wr_rdn_d = 1'b0;
              addr_d   = hdr_nx[ADDR_W-1:0];
              state_d  = RD_REQ;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end

      RD_REQ: begin
        if (cs_s) cshi_d = 1'b1;
        if (cs_s || !ena) quit_d = 1'b1;
        // host keeps clocking while the bank is slow
        if (rise && !cs_s && cnt_q != DAT_ALL) begin
          cnt_d  = cnt_q + ONE;
          late_d = 1'b1;
        end
        if (ack) begin
          we_d   = 1'b0;
          berr_d = err;
          if (quit_d) begin
            state_d = IDLE;
            abort_d = cshi_d && (cnt_d != DAT_ALL);
          end else if (cnt_d == DAT_ALL) begin
            state_d = DONE;
          end else begin
            state_d = DATA;
            if (!late_d) begin
              tx_d   = rdata;
              miso_d = rdata[REG_W-1];
            end
          end
        end
      end

      WDATA: begin
        if (cs_s) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (!ena) begin
          state_d = IDLE;
        end else if (rise) begin
          rx_d = rx_nx;
          if (cnt_q == DAT_LAST) begin
            we_d     = 1'b1;
            wr_rdn_d = 1'b1;
            addr_d   = hdr_q[ADDR_W-1:0];
            wdata_d  = rx_nx;
            state_d  = WR_REQ;
          end
          cnt_d = cnt_q + ONE;
        end
      end

      DATA: begin
        if (cs_s) begin
          abort_d = 1'b1;
          miso_d  = 1'b0;
          state_d = IDLE;
        end else if (!ena) begin
          miso_d  = 1'b0;
          state_d = IDLE;
        end else if (rise) begin
          rose_d = 1'b1;
          cnt_d  = cnt_q + ONE;
          if (cnt_q == DAT_LAST) begin
            miso_d  = 1'b0;
            state_d = DONE;
          end
        end else if (fall && rose_q && !late_q) begin
          tx_d   = {tx_q[REG_W-2:0], 1'b0};
          miso_d = tx_q[REG_W-2];
        end
      end

      WR_REQ: begin
        if (cs_s || !ena) quit_d = 1'b1;
        if (ack) begin
          we_d    = 1'b0;
          berr_d  = err;
          state_d = quit_d ? IDLE : DONE;
        end
      end

      DONE: begin
        miso_d = 1'b0;
        if (cs_s || !ena) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hdr_q    <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      miso_q   <= 1'b0;
      we_q     <= 1'b0;
      wr_rdn_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      berr_q   <= 1'b0;
      abort_q  <= 1'b0;
      late_q   <= 1'b0;
      rose_q   <= 1'b0;
      quit_q   <= 1'b0;
      cshi_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hdr_q    <= hdr_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      miso_q   <= miso_d;
      we_q     <= we_d;
      wr_rdn_q <= wr_rdn_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      berr_q   <= berr_d;
      abort_q  <= abort_d;
      late_q   <= late_d;
      rose_q   <= rose_d;
      quit_q   <= quit_d;
      cshi_q   <= cshi_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = ena & ~cs_s;
  assign we          = we_q;
  assign wr_rdn      = wr_rdn_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign bus_err     = berr_q;
  assign frame_abort = abort_q;

endmodule
